// File: rtl/sp_tracker.sv
// Two-axis solar tracker: 50 Hz servo PWM, manual jog and an automatic max-power scan.
// Optional macro SP_BTN_DEBOUNCE_EN adds a 16-tick stability filter on the synchronized buttons.
module sp_tracker #(
    parameter logic [31:0] PWM_PERIOD   = 32'd2000000,
    parameter logic [31:0] POS_MIN      = 32'd100000,
    parameter logic [31:0] POS_MAX      = 32'd200000,
    parameter logic [31:0] POS_CENTER   = 32'd150000,
    parameter logic [31:0] JOG_STEP     = 32'd100,
    parameter logic [31:0] SCAN_STEP    = 32'd1000,
    parameter logic [31:0] MOVE_DIV     = 32'd1000,
    parameter logic [31:0] SETTLE_TICKS = 32'd4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BTN_L,
    input  logic        BTN_R,
    input  logic        BTN_U,
    input  logic        BTN_D,
    input  logic        BTN_C,
    input  logic [11:0] V_in,
    output logic [11:0] max_V_in,
    output logic [31:0] pulseWidth_max,
    output logic [1:0]  direction_lr,
    output logic [1:0]  direction_ud,
    output logic        servo_l,
    output logic        servo_r,
    output logic        servo_u,
    output logic        servo_d,
    output logic        SERVO_H,
    output logic        SERVO_V,
    output logic [31:0] servo_position_H,
    output logic [31:0] servo_position_V,
    output logic [2:0]  STAT
);

    typedef enum logic [2:0] {
        ST_MANUAL = 3'd0,
        ST_SCAN_H = 3'd1,
        ST_GOTO_H = 3'd2,
        ST_SCAN_V = 3'd3,
        ST_GOTO_V = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    logic [4:0]  sync1_q, sync2_q, btn;
    logic        c_prev_q, c_rise, tick;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] shadow_h_q, shadow_h_d, shadow_v_q, shadow_v_d;
    logic        servo_h_q, servo_v_q;
    state_t      state_q, state_d;
    logic [31:0] pos_h_q, pos_h_d, pos_v_q, pos_v_d;
    logic [11:0] max_q, max_d;
    logic [31:0] pwmax_q, pwmax_d;
    logic [31:0] settle_q, settle_d;
    logic        jog_en, l_act, r_act, u_act, d_act;
    logic [31:0] scan_pos, cap_pw;
    logic [11:0] cap_max;
    logic        hit, last_step;

    // Saturation is tested before the arithmetic so the 32-bit position can never wrap.
    function automatic logic [31:0] jog_dec(input logic [31:0] pos);
        return (pos >= POS_MIN + JOG_STEP) ? pos - JOG_STEP : POS_MIN;
    endfunction

    function automatic logic [31:0] jog_inc(input logic [31:0] pos);
        return (pos <= POS_MAX - JOG_STEP) ? pos + JOG_STEP : POS_MAX;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            c_prev_q <= 1'b0;
        end else begin
            sync1_q  <= {BTN_C, BTN_D, BTN_U, BTN_R, BTN_L};
            sync2_q  <= sync1_q;
            c_prev_q <= btn[4];
        end
    end

`ifdef SP_BTN_DEBOUNCE_EN
    logic [4:0]      deb_q, deb_d;
    logic [4:0][3:0] deb_cnt_q, deb_cnt_d;

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = 4'd0;
            end else if (tick) begin
                if (deb_cnt_q[i] == 4'd15) begin
                    deb_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = 4'd0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb_q     <= '0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign btn = deb_q;
`else
    assign btn = sync2_q;
`endif

    assign c_rise = btn[4] & ~c_prev_q;
    assign tick   = (tick_cnt_q == MOVE_DIV - 32'd1);

    always_comb begin
        tick_cnt_d  = tick ? 32'd0 : tick_cnt_q + 32'd1;
        frame_cnt_d = (frame_cnt_q == PWM_PERIOD - 32'd1) ? 32'd0 : frame_cnt_q + 32'd1;
        shadow_h_d  = (frame_cnt_q == PWM_PERIOD - 32'd1) ? pos_h_q : shadow_h_q;
        shadow_v_d  = (frame_cnt_q == PWM_PERIOD - 32'd1) ? pos_v_q : shadow_v_q;
    end

    // Jogging is only honoured while the operator owns the servos.
    assign jog_en = (state_q == ST_MANUAL) || (state_q == ST_DONE);
    assign l_act  = jog_en & btn[0] & ~btn[1];
    assign r_act  = jog_en & btn[1] & ~btn[0];
    assign u_act  = jog_en & btn[2] & ~btn[3];
    assign d_act  = jog_en & btn[3] & ~btn[2];

    assign scan_pos  = (state_q == ST_SCAN_H) ? pos_h_q : pos_v_q;
    assign hit       = (V_in > max_q);
    assign cap_max   = hit ? V_in : max_q;
    assign cap_pw    = hit ? scan_pos : pwmax_q;
    assign last_step = (scan_pos > POS_MAX - SCAN_STEP);

    always_comb begin
        state_d  = state_q;
        pos_h_d  = pos_h_q;
        pos_v_d  = pos_v_q;
        max_d    = max_q;
        pwmax_d  = pwmax_q;
        settle_d = settle_q;
        if (c_rise) begin
            state_d  = ST_SCAN_H;
            pos_h_d  = POS_MIN;
            max_d    = '0;
            pwmax_d  = POS_MIN;
            settle_d = '0;
        end else begin
            case (state_q)
                ST_MANUAL: begin
                    if (tick) begin
                        if (l_act)      pos_h_d = jog_dec(pos_h_q);
                        else if (r_act) pos_h_d = jog_inc(pos_h_q);
                        if (d_act)      pos_v_d = jog_dec(pos_v_q);
                        else if (u_act) pos_v_d = jog_inc(pos_v_q);
                    end
                end
                ST_SCAN_H, ST_SCAN_V: begin
                    if (tick) begin
                        max_d   = cap_max;
                        pwmax_d = cap_pw;
                        if (last_step) begin
                            settle_d = '0;
                            if (state_q == ST_SCAN_H) begin
                                state_d = ST_GOTO_H;
                                pos_h_d = cap_pw;
                            end else begin
                                state_d = ST_GOTO_V;
                                pos_v_d = cap_pw;
                            end
                        end else if (state_q == ST_SCAN_H) begin
                            pos_h_d = pos_h_q + SCAN_STEP;
                        end else begin
                            pos_v_d = pos_v_q + SCAN_STEP;
                        end
                    end
                end
                ST_GOTO_H, ST_GOTO_V: begin
                    if (tick) begin
                        if (settle_q == SETTLE_TICKS - 32'd1) begin
                            settle_d = '0;
                            if (state_q == ST_GOTO_H) begin
                                state_d = ST_SCAN_V;
                                pos_v_d = POS_MIN;
                                max_d   = '0;
                                pwmax_d = POS_MIN;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            settle_d = settle_q + 32'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (|btn[3:0]) state_d = ST_MANUAL;
                end
                default: state_d = ST_MANUAL;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt_q  <= '0;
            frame_cnt_q <= '0;
            shadow_h_q  <= POS_CENTER;
            shadow_v_q  <= POS_CENTER;
            servo_h_q   <= 1'b0;
            servo_v_q   <= 1'b0;
            state_q     <= ST_MANUAL;
            pos_h_q     <= POS_CENTER;
            pos_v_q     <= POS_CENTER;
            max_q       <= '0;
            pwmax_q     <= POS_CENTER;
            settle_q    <= '0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            shadow_h_q  <= shadow_h_d;
            shadow_v_q  <= shadow_v_d;
            servo_h_q   <= (frame_cnt_q < shadow_h_q);
            servo_v_q   <= (frame_cnt_q < shadow_v_q);
            state_q     <= state_d;
            pos_h_q     <= pos_h_d;
            pos_v_q     <= pos_v_d;
            max_q       <= max_d;
            pwmax_q     <= pwmax_d;
            settle_q    <= settle_d;
        end
    end

    assign max_V_in         = max_q;
    assign pulseWidth_max   = pwmax_q;
    assign direction_lr     = {r_act, l_act};
    assign direction_ud     = {d_act, u_act};
    assign servo_l          = l_act;
    assign servo_r          = r_act;
    assign servo_u          = u_act;
    assign servo_d          = d_act;
    assign SERVO_H          = servo_h_q;
    assign SERVO_V          = servo_v_q;
    assign servo_position_H = pos_h_q;
    assign servo_position_V = pos_v_q;
    assign STAT             = state_q;

endmodule

// File: tb/tb_sp_tracker.sv
// Directed bench for sp_tracker with scaled timing: 400-cycle frames, positions 100..200, tick every 10 cycles.
module tb_sp_tracker;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        BTN_L = 1'b0, BTN_R = 1'b0, BTN_U = 1'b0, BTN_D = 1'b0, BTN_C = 1'b0;
    logic [11:0] V_in = '0;
    logic [11:0] max_V_in;
    logic [31:0] pulseWidth_max;
    logic [1:0]  direction_lr, direction_ud;
    logic        servo_l, servo_r, servo_u, servo_d;
    logic        SERVO_H, SERVO_V;
    logic [31:0] servo_position_H, servo_position_V;
    logic [2:0]  STAT;

    int n_tests = 0;
    int n_fail  = 0;

    sp_tracker #(
        .PWM_PERIOD(32'd400), .POS_MIN(32'd100), .POS_MAX(32'd200), .POS_CENTER(32'd150),
        .JOG_STEP(32'd3), .SCAN_STEP(32'd10), .MOVE_DIV(32'd10), .SETTLE_TICKS(32'd4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .BTN_L(BTN_L), .BTN_R(BTN_R), .BTN_U(BTN_U), .BTN_D(BTN_D), .BTN_C(BTN_C),
        .V_in(V_in),
        .max_V_in(max_V_in), .pulseWidth_max(pulseWidth_max),
        .direction_lr(direction_lr), .direction_ud(direction_ud),
        .servo_l(servo_l), .servo_r(servo_r), .servo_u(servo_u), .servo_d(servo_d),
        .SERVO_H(SERVO_H), .SERVO_V(SERVO_V),
        .servo_position_H(servo_position_H), .servo_position_V(servo_position_V),
        .STAT(STAT)
    );

    always #5 CLK = ~CLK;

    // Measures the next complete PWM pulse (rise to fall) and the rise-to-rise period; -1 on timeout.
    task automatic measure_pulse(input bit use_v, output int width, output int period);
        bit prev, cur, found;
        width = -1;
        period = -1;
        found = 1'b0;
        prev = use_v ? SERVO_V : SERVO_H;
        for (int t = 0; t < 1000 && !found; t++) begin
            @(negedge CLK);
            cur = use_v ? SERVO_V : SERVO_H;
            if (cur && !prev) found = 1'b1;
            prev = cur;
        end
        if (found) begin
            width = 1;
            found = 1'b0;
            for (int t = 1; t < 1000 && !found; t++) begin
                @(negedge CLK);
                cur = use_v ? SERVO_V : SERVO_H;
                if (cur && !prev) begin
                    period = t;
                    found = 1'b1;
                end
                if (cur && period < 0 && t == width) width++;
                prev = cur;
            end
        end
    endtask

    task automatic test_reset();
        int w, p;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_tests++;
        if (STAT !== 3'd0 || SERVO_H !== 1'b0 || SERVO_V !== 1'b0 || max_V_in !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_hold: STAT=%0d SERVO_H=%b SERVO_V=%b max=%0d, required 0/0/0/0", STAT, SERVO_H, SERVO_V, max_V_in);
        end
        RST = 1'b0;
        repeat (3 * 400) @(negedge CLK);
        n_tests++;
        if (servo_position_H !== 32'd150 || servo_position_V !== 32'd150 || pulseWidth_max !== 32'd150 || STAT !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle: H=%0d V=%0d pwmax=%0d STAT=%0d, required 150/150/150/0", servo_position_H, servo_position_V, pulseWidth_max, STAT);
        end
        measure_pulse(1'b0, w, p);
        n_tests++;
        if (w !== 150 || p !== 400) begin
            n_fail++;
            $display("FAIL pwm_h_center: width=%0d period=%0d, required 150/400", w, p);
        end
        measure_pulse(1'b1, w, p);
        n_tests++;
        if (w !== 150) begin
            n_fail++;
            $display("FAIL pwm_v_center: width=%0d, required 150", w);
        end
    endtask

    task automatic test_jog_up();
        int w, p;
        bit prev, found, ended;
        found = 1'b0;
        prev = SERVO_V;
        for (int t = 0; t < 1000 && !found; t++) begin
            @(negedge CLK);
            if (SERVO_V && !prev) found = 1'b1;
            prev = SERVO_V;
        end
        BTN_U = 1'b1;
        w = 1;
        ended = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (i == 100) BTN_U = 1'b0;
            if (i == 50) begin
                n_tests++;
                if (servo_u !== 1'b1 || direction_ud !== 2'b01 || servo_d !== 1'b0) begin
                    n_fail++;
                    $display("FAIL jog_up_flags: servo_u=%b dir_ud=%b servo_d=%b, required 1/01/0", servo_u, direction_ud, servo_d);
                end
            end
            if (!ended) begin
                if (SERVO_V) w++;
                else ended = 1'b1;
            end
        end
        n_tests++;
        if (!found || w !== 150) begin
            n_fail++;
            $display("FAIL jog_up_current_frame: width=%0d, required 150", w);
        end
        n_tests++;
        if (servo_position_V !== 32'd180 || servo_u !== 1'b0 || direction_ud !== 2'b00) begin
            n_fail++;
            $display("FAIL jog_up_pos: V=%0d servo_u=%b dir_ud=%b, required 180/0/00", servo_position_V, servo_u, direction_ud);
        end
        measure_pulse(1'b1, w, p);
        n_tests++;
        if (w !== 180) begin
            n_fail++;
            $display("FAIL jog_up_next_frame: width=%0d, required 180", w);
        end
    endtask

    task automatic test_saturation();
        BTN_L = 1'b1;
        repeat (250) @(negedge CLK);
        n_tests++;
        if (servo_l !== 1'b1 || direction_lr !== 2'b01) begin
            n_fail++;
            $display("FAIL jog_left_flags: servo_l=%b dir_lr=%b, required 1/01", servo_l, direction_lr);
        end
        repeat (250) @(negedge CLK);
        n_tests++;
        if (servo_position_H !== 32'd100) begin
            n_fail++;
            $display("FAIL sat_min: H=%0d, required 100", servo_position_H);
        end
        BTN_R = 1'b1;
        repeat (100) @(negedge CLK);
        n_tests++;
        if (servo_position_H !== 32'd100 || direction_lr !== 2'b00 || servo_l !== 1'b0 || servo_r !== 1'b0) begin
            n_fail++;
            $display("FAIL lr_both: H=%0d dir_lr=%b l=%b r=%b, required 100/00/0/0", servo_position_H, direction_lr, servo_l, servo_r);
        end
        BTN_L = 1'b0;
        repeat (600) @(negedge CLK);
        n_tests++;
        if (servo_position_H !== 32'd200 || direction_lr !== 2'b10 || servo_r !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_max: H=%0d dir_lr=%b r=%b, required 200/10/1", servo_position_H, direction_lr, servo_r);
        end
        BTN_R = 1'b0;
        BTN_U = 1'b1;
        BTN_D = 1'b1;
        repeat (100) @(negedge CLK);
        n_tests++;
        if (servo_position_V !== 32'd180 || direction_ud !== 2'b00 || servo_u !== 1'b0) begin
            n_fail++;
            $display("FAIL ud_both: V=%0d dir_ud=%b u=%b, required 180/00/0", servo_position_V, direction_ud, servo_u);
        end
        BTN_U = 1'b0;
        BTN_D = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_scan();
        logic [31:0] seq;
        logic [2:0]  prev_stat;
        bit          seen_goto_h;
        seq = '0;
        prev_stat = STAT;
        seen_goto_h = 1'b0;
        BTN_C = 1'b1;
        for (int cyc = 0; cyc < 3000 && STAT !== 3'd5; cyc++) begin
            @(negedge CLK);
            if (cyc == 3) BTN_C = 1'b0;
            if (STAT !== prev_stat) seq = {seq[27:0], 1'b0, STAT};
            prev_stat = STAT;
            if (STAT === 3'd2 && !seen_goto_h) begin
                seen_goto_h = 1'b1;
                n_tests++;
                if (max_V_in !== 12'd4095 || pulseWidth_max !== 32'd150 || servo_position_H !== 32'd150) begin
                    n_fail++;
                    $display("FAIL scan_h_peak: max=%0d pwmax=%0d H=%0d, required 4095/150/150", max_V_in, pulseWidth_max, servo_position_H);
                end
                n_tests++;
                if (direction_lr !== 2'b00 || servo_l !== 1'b0) begin
                    n_fail++;
                    $display("FAIL scan_dirs: dir_lr=%b l=%b, required 00/0", direction_lr, servo_l);
                end
            end
            if (STAT === 3'd1)
                V_in = (servo_position_H == 32'd150) ? 12'd4095 : 12'd0;
            else if (STAT === 3'd3)
                V_in = (servo_position_V == 32'd120 || servo_position_V == 32'd180) ? 12'd3000 : 12'd0;
            else
                V_in = 12'd0;
        end
        n_tests++;
        if (seq !== 32'h0001_2345) begin
            n_fail++;
            $display("FAIL scan_sequence: states=%h, required 00012345", seq);
        end
        n_tests++;
        if (max_V_in !== 12'd3000 || pulseWidth_max !== 32'd120 || servo_position_V !== 32'd120 || servo_position_H !== 32'd150) begin
            n_fail++;
            $display("FAIL scan_v_result: max=%0d pwmax=%0d V=%0d H=%0d, required 3000/120/120/150", max_V_in, pulseWidth_max, servo_position_V, servo_position_H);
        end
        repeat (50) @(negedge CLK);
        n_tests++;
        if (STAT !== 3'd5 || servo_position_H !== 32'd150) begin
            n_fail++;
            $display("FAIL done_hold: STAT=%0d H=%0d, required 5/150", STAT, servo_position_H);
        end
    endtask

    task automatic test_done_exit();
        BTN_R = 1'b1;
        repeat (50) @(negedge CLK);
        n_tests++;
        if (STAT !== 3'd0 || servo_position_H <= 32'd150 || servo_position_H > 32'd165) begin
            n_fail++;
            $display("FAIL done_exit: STAT=%0d H=%0d, required 0 and H in 151..165", STAT, servo_position_H);
        end
        BTN_R = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_tie_hold_c();
        logic [2:0] prev_stat;
        int         scan_entries;
        bit         checked;
        prev_stat = STAT;
        scan_entries = 0;
        checked = 1'b0;
        V_in = 12'd2000;
        BTN_C = 1'b1;
        for (int cyc = 0; cyc < 3000 && STAT !== 3'd5; cyc++) begin
            @(negedge CLK);
            if (STAT === 3'd1 && prev_stat !== 3'd1) scan_entries++;
            prev_stat = STAT;
            if (STAT === 3'd2 && !checked) begin
                checked = 1'b1;
                n_tests++;
                if (max_V_in !== 12'd2000 || pulseWidth_max !== 32'd100 || servo_position_H !== 32'd100) begin
                    n_fail++;
                    $display("FAIL tie_earliest: max=%0d pwmax=%0d H=%0d, required 2000/100/100", max_V_in, pulseWidth_max, servo_position_H);
                end
            end
        end
        n_tests++;
        if (STAT !== 3'd5 || scan_entries !== 1 || !checked) begin
            n_fail++;
            $display("FAIL c_held_no_retrigger: STAT=%0d scan_entries=%0d, required 5/1", STAT, scan_entries);
        end
        BTN_C = 1'b0;
        V_in = 12'd0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_reset_mid_scan();
        bit reached;
        reached = 1'b0;
        V_in = 12'd1234;
        BTN_C = 1'b1;
        for (int cyc = 0; cyc < 3000 && !reached; cyc++) begin
            @(negedge CLK);
            if (cyc == 3) BTN_C = 1'b0;
            if (STAT === 3'd3 && servo_position_V == 32'd130) reached = 1'b1;
        end
        n_tests++;
        if (!reached) begin
            n_fail++;
            $display("FAIL reach_scan_v: STAT=%0d, required 3 within 3000 cycles", STAT);
        end
        RST = 1'b1;
        #1;
        n_tests++;
        if (STAT !== 3'd0 || servo_position_H !== 32'd150 || servo_position_V !== 32'd150) begin
            n_fail++;
            $display("FAIL async_reset_state: STAT=%0d H=%0d V=%0d, required 0/150/150", STAT, servo_position_H, servo_position_V);
        end
        n_tests++;
        if (max_V_in !== 12'd0 || pulseWidth_max !== 32'd150 || SERVO_H !== 1'b0 || SERVO_V !== 1'b0 ||
            direction_lr !== 2'b00 || direction_ud !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_outputs: max=%0d pwmax=%0d SH=%b SV=%b lr=%b ud=%b, required 0/150/0/0/00/00",
                     max_V_in, pulseWidth_max, SERVO_H, SERVO_V, direction_lr, direction_ud);
        end
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        V_in = 12'd0;
        repeat (5) @(negedge CLK);
        n_tests++;
        if (STAT !== 3'd0) begin
            n_fail++;
            $display("FAIL after_reset_manual: STAT=%0d, required 0", STAT);
        end
    endtask

    initial begin
        test_reset();
        test_jog_up();
        test_saturation();
        test_scan();
        test_done_exit();
        test_tie_hold_c();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_tracker.md
Name: sp_tracker

Overview:
- Two-axis solar-panel positioner: drives horizontal and vertical hobby servos with 50 Hz PWM and finds the maximum-power orientation from a 12-bit ADC sample (V_in).
- Manual jog via L/R/U/D buttons; BTN_C starts an automatic scan (H sweep, go to best H, V sweep, go to best V).
- Sits between the ADC front end and the servo pins; exposes tracking state for display and debug.

Parameters:
- PWM_PERIOD, 2000000, PWM frame length in CLK cycles (20 ms at 100 MHz).
- POS_MIN, 100000, minimum pulse width in cycles (1 ms).
- POS_MAX, 200000, maximum pulse width in cycles (2 ms).
- POS_CENTER, 150000, reset/home pulse width.
- JOG_STEP, 100, pulse-width change per manual move tick.
- SCAN_STEP, 1000, pulse-width change per scan tick.
- MOVE_DIV, 1000, CLK cycles per move/scan tick.
- SETTLE_TICKS, 4, move ticks to wait in each GOTO state.

Ports:
- CLK in 1 system clock, 100 MHz
- RST in 1 asynchronous reset, active-high
- BTN_L in 1 jog horizontal down (decrease servo_position_H)
- BTN_R in 1 jog horizontal up
- BTN_U in 1 jog vertical up (increase servo_position_V)
- BTN_D in 1 jog vertical down
- BTN_C in 1 start/restart auto scan (rising edge)
- V_in in 12 ADC sample, unsigned
- max_V_in out 12 largest V_in seen in current sweep
- pulseWidth_max out 32 servo position at which max_V_in occurred
- direction_lr out 2 00 none, 01 left, 10 right
- direction_ud out 2 00 none, 01 up, 10 down
- servo_l/servo_r/servo_u/servo_d out 1 each, high while that jog is active
- SERVO_H out 1 horizontal PWM
- SERVO_V out 1 vertical PWM
- servo_position_H out 32 commanded H pulse width (cycles)
- servo_position_V out 32 commanded V pulse width (cycles)
- STAT out 3 FSM state code

Behaviour:
- Reset values: servo_position_H/V = POS_CENTER; max_V_in = 0; pulseWidth_max = POS_CENTER; STAT = 0; direction_lr/ud = 00; servo_l/r/u/d = 0; SERVO_H/V = 0; all counters 0. Reset mid-scan aborts to MANUAL.
- Buttons pass a 2-flop synchronizer (2-cycle latency). V_in is sampled directly.
- Tick: free-running counter, one-cycle pulse every MOVE_DIV cycles.
- PWM: frame counter 0..PWM_PERIOD-1. SERVO_x = (cnt < shadow_x). The shadow register loads servo_position_x when cnt == PWM_PERIOD-1, so position changes take effect only at frame start. After reset, shadow = POS_CENTER.
- FSM states (STAT code):
  - MANUAL (0): on each tick, BTN_L alone subtracts JOG_STEP from H; BTN_R alone adds it. BTN_U/BTN_D act the same on V. Results saturate at POS_MIN/POS_MAX. L+R both held: no H move, direction_lr = 00 (same rule for U+D). servo_x and direction reflect the synchronized buttons combinationally from registers.
  - SCAN_H (1): on entry, H = POS_MIN, max_V_in = 0, pulseWidth_max = POS_MIN. Each tick: if V_in > max_V_in (strictly greater), capture V_in and current H; then H += SCAN_STEP. Past POS_MAX → GOTO_H.
  - GOTO_H (2): H = pulseWidth_max; wait SETTLE_TICKS → SCAN_V.
  - SCAN_V (3): same as SCAN_H on the V axis; max_V_in and pulseWidth_max are reset at entry.
  - GOTO_V (4): V = pulseWidth_max; settle → DONE.
  - DONE (5): hold positions. L/R/U/D return the FSM to MANUAL and jog normally.
- A BTN_C rising edge in any state enters SCAN_H and has priority over jog buttons. In scan/goto states, L/R/U/D are ignored and servo_l..d and directions read 0. BTN_C held high does not retrigger.
- Ties on V_in keep the earliest position.
- Width rules: positions are 32-bit unsigned; saturation is checked before the add/subtract so there is no wrap-around.

Optional Feature:
- SP_BTN_DEBOUNCE_EN defined: each synchronized button must be stable for 16 consecutive ticks before its debounced value changes.
- Undefined: synchronizer output is used directly, so a 1-cycle pulse is seen if it is captured.

Test Plan:
- Reset, then 3 frames idle → servo_position_H/V = 150000, SERVO_H high exactly 150000 cycles per 2000000-cycle frame, STAT = 0.
- Hold BTN_U 10000 cycles → servo_position_V = 151000 (10 ticks), servo_u = 1 and direction_ud = 01 while held; SERVO_V width changes only at next frame start.
- Hold BTN_L from POS_MIN+50 → H saturates at 100000, no underflow; L+R together → no change, direction_lr = 00.
- Pulse BTN_C, V_in = 4095 only when H = 150000 and 0 otherwise → STAT goes 1→2, max_V_in = 4095, pulseWidth_max = 150000, H settles at 150000; then V scan → STAT 3→4→5.
- Constant V_in = 2000 during scan → pulseWidth_max = POS_MIN (earliest tie kept).
- Assert RST during SCAN_V → all outputs return to reset values immediately (asynchronously); STAT = 0.
